// File: rtl/mem_reader_pkg.sv
// Shared definitions for the memory read sequencer: FSM encoding and default widths.
package mem_reader_pkg;

   localparam int DEF_AWIDTH = 5;
   localparam int DEF_DWIDTH = 8;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_READ  = 2'd1,
      RD_DRAIN = 2'd2,
      RD_DONE  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/mem_reader_if.sv
// Burst control, memory read port and output stream of the read sequencer.
interface mem_reader_if
   import mem_reader_pkg::*;
#(
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int DWIDTH = DEF_DWIDTH
);
   logic              start;
   logic [AWIDTH-1:0] base_addr;
   logic [AWIDTH-1:0] count;
   logic              busy;
   logic              done;
   logic              mem_rd;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_rdata;
   logic [DWIDTH-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  start, base_addr, count, mem_rdata, out_ready,
      output busy, done, mem_rd, mem_addr, out_data, out_valid
   );

   modport slave (
      output start, base_addr, count, mem_rdata, out_ready,
      input  busy, done, mem_rd, mem_addr, out_data, out_valid
   );
endinterface

// File: rtl/mem_reader_fifo.sv
// Synchronous FIFO used as the output buffer; head word is presented from storage.
module sync_fifo #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DWIDTH-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DWIDTH-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   // A write into a full buffer is legal when the head leaves in the same cycle.
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/mem_reader.sv
// Burst read sequencer: issues sequential memory reads under buffer credit and streams words out.
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int AWIDTH     = DEF_AWIDTH,
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   mem_reader_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rd_state_e         state;
   rd_state_e         state_nx;
   logic [AWIDTH-1:0] addr;
   logic [AWIDTH-1:0] remaining;
   logic [RD_LAT-1:0] vld_pipe;
   logic [CW-1:0]     occupancy;
   logic [CW-1:0]     in_flight;
   logic [CW:0]       credit_sum;
   logic              credit_ok;
   logic              rd_fire;
   logic              wr_fire;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic              drained;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(vld_pipe[i]);
   end

   // Credit counts buffered words plus reads still in the memory pipe; out_ready is not used here.
   assign credit_sum = (CW+1)'(occupancy) + (CW+1)'(in_flight);
   assign credit_ok  = ~fifo_full & (credit_sum < (CW+1)'(FIFO_DEPTH));
   assign rd_fire    = (state == RD_READ) & credit_ok;
   assign wr_fire    = vld_pipe[RD_LAT-1];
   assign pop        = bus.out_valid & bus.out_ready;
   // Lookahead: the buffer empties at this edge and nothing remains in flight.
   assign drained    = (vld_pipe == '0) &
                       (fifo_empty | ((occupancy == CW'(1)) & pop));

   assign bus.mem_rd    = rd_fire;
   assign bus.mem_addr  = addr;
   assign bus.busy      = (state != RD_IDLE);
   assign bus.done      = (state == RD_DONE);
   assign bus.out_valid = ~fifo_empty;

   always_comb begin
      state_nx = state;
      case (state)
         // An empty burst still spends one cycle in DRAIN so done follows start by two cycles.
         RD_IDLE:  if (bus.start) state_nx = (bus.count == '0) ? RD_DRAIN : RD_READ;
         RD_READ:  if (rd_fire && remaining == AWIDTH'(1)) state_nx = RD_DRAIN;
         RD_DRAIN: if (drained) state_nx = RD_DONE;
         RD_DONE:  state_nx = RD_IDLE;
         default:  state_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RD_IDLE;
         addr      <= '0;
         remaining <= '0;
         vld_pipe  <= '0;
      end else begin
         state       <= state_nx;
         vld_pipe[0] <= rd_fire;
         for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
         if (state == RD_IDLE && bus.start) begin
            addr      <= bus.base_addr;
            remaining <= bus.count;
         end else if (rd_fire) begin
            addr      <= addr + AWIDTH'(1);
            remaining <= remaining - AWIDTH'(1);
         end
      end
   end

   sync_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (FIFO_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire),
      .wr_data (bus.mem_rdata),
      .rd_en   (pop),
      .rd_data (bus.out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (occupancy)
   );
endmodule

// File: tb/tb_mem_reader.sv
// Bench for mem_reader: a RD_LAT=1 instance checked cycle by cycle and a RD_LAT=3 instance under random back-pressure.
module tb_mem_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   got_a    = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [4:0] apa;
   logic [4:0] apb [3];

   always #10 clk = ~clk;

   mem_reader_if #(.AWIDTH(5), .DWIDTH(8)) ifa ();
   mem_reader_if #(.AWIDTH(5), .DWIDTH(8)) ifb ();

   mem_reader #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(1), .FIFO_DEPTH(4))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mem_reader #(.AWIDTH(5), .DWIDTH(8), .RD_LAT(3), .FIFO_DEPTH(4))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // Memory model: mem[a] = a ^ A5, returned RD_LAT cycles after the address cycle.
   always @(posedge clk) begin
      apa    <= ifa.mem_addr;
      apb[0] <= ifb.mem_addr;
      apb[1] <= apb[0];
      apb[2] <= apb[1];
   end
   assign ifa.mem_rdata = {3'b000, apa} ^ 8'hA5;
   assign ifb.mem_rdata = {3'b000, apb[2]} ^ 8'hA5;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (ifa.out_valid && ifa.out_ready) begin
         if (qa.size() == 0) chk("out_a_unexpected", int'(ifa.out_data), -1);
         else chk("out_a_word", int'(ifa.out_data), int'(qa.pop_front()));
         got_a++;
      end
   end

   always @(negedge clk) begin
      #1;
      if (ifb.out_valid && ifb.out_ready) begin
         if (qb.size() == 0) chk("out_b_unexpected", int'(ifb.out_data), -1);
         else chk("out_b_word", int'(ifb.out_data), int'(qb.pop_front()));
      end
   end

   task automatic drive(input bit sel, input bit st, input int base, input int cnt, input bit rdy);
      if (sel) begin
         ifb.start = st; ifb.base_addr = 5'(base); ifb.count = 5'(cnt); ifb.out_ready = rdy;
      end else begin
         ifa.start = st; ifa.base_addr = 5'(base); ifa.count = 5'(cnt); ifa.out_ready = rdy;
      end
   endtask

   function automatic bit ready_val(input bit sel, input int k, input int hold0);
      if (k < hold0) return 1'b0;
      return sel ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   // exp_done < 0 skips the done-cycle check; exp_first == -2 skips the first-valid check.
   task automatic burst(input bit sel, input int base, input int cnt, input int hold0,
                        input int restart_k, input int exp_done, input int exp_first);
      int nrd = 0, rd_hold = 0, first_v = -1, done_k = -1, done_cnt = 0;
      bit st, rd, ov, dn, bz;
      logic [4:0] ad;
      for (int i = 0; i < cnt; i++) begin
         if (sel) qb.push_back(8'((base + i) & 31) ^ 8'hA5);
         else     qa.push_back(8'((base + i) & 31) ^ 8'hA5);
      end
      @(negedge clk);
      drive(sel, 1'b1, base, cnt, ready_val(sel, 0, hold0));
      for (int k = 1; k < 400; k++) begin
         @(negedge clk);
         st = (k == restart_k);
         drive(sel, st, st ? 9 : base, st ? 3 : cnt, ready_val(sel, k, hold0));
         #2;
         rd = sel ? ifb.mem_rd    : ifa.mem_rd;
         ad = sel ? ifb.mem_addr  : ifa.mem_addr;
         ov = sel ? ifb.out_valid : ifa.out_valid;
         dn = sel ? ifb.done      : ifa.done;
         bz = sel ? ifb.busy      : ifa.busy;
         if (rd) begin
            chk("mem_addr", int'(ad), (base + nrd) & 31);
            nrd++;
            if (k < hold0) rd_hold++;
         end
         if (ov && first_v < 0) first_v = k;
         if (k == 1) chk("busy_after_start", int'(bz), 1);
         if (dn) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k == done_k + 1) begin
            chk("busy_after_done", int'(bz), 0);
            break;
         end
      end
      chk("done_seen", int'(done_k >= 0), 1);
      chk("done_pulses", done_cnt, 1);
      chk("read_count", nrd, cnt);
      if (exp_done >= 0) chk("done_cycle", done_k, exp_done);
      if (exp_first >= -1) chk("first_valid_cycle", first_v, exp_first);
      if (hold0 > 0) chk("reads_while_stalled", rd_hold, (cnt < 4) ? cnt : 4);
   endtask

   initial begin
      int dn_cnt;
      drive(1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy",      int'(ifa.busy), 0);
      chk("rst_done",      int'(ifa.done), 0);
      chk("rst_mem_rd",    int'(ifa.mem_rd), 0);
      chk("rst_mem_addr",  int'(ifa.mem_addr), 0);
      chk("rst_out_valid", int'(ifa.out_valid), 0);
      chk("rst_out_data",  int'(ifa.out_data), 0);
      rst = 1'b0;
      @(negedge clk);

      burst(1'b0, 3, 4, 0, 0, 7, 3);       // A6 A1 A0 A3
      burst(1'b0, 30, 4, 0, 0, 7, 3);      // wrap: BB BA A5 A4
      burst(1'b0, 12, 8, 10, 0, -1, -2);   // stalled consumer
      burst(1'b0, 5, 0, 0, 0, 2, -1);      // empty burst
      burst(1'b0, 5, 4, 0, 2, 7, 3);       // restart attempt while busy

      // Reset after two of six words have been handed off.
      for (int i = 0; i < 6; i++) qa.push_back(8'((10 + i) & 31) ^ 8'hA5);
      got_a = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 10, 6, 1'b1);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 10, 6, 1'b1);
         #2;
         if (got_a >= 2) break;
      end
      chk("words_before_rst", got_a, 2);
      @(negedge clk);
      rst = 1'b1;
      ifa.out_ready = 1'b0;
      dn_cnt = int'(ifa.done);
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("rst_mid_busy",      int'(ifa.busy), 0);
      chk("rst_mid_out_valid", int'(ifa.out_valid), 0);
      qa.delete();
      ifa.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dn_cnt += int'(ifa.done) + int'(ifa.out_valid);
         @(negedge clk);
         #2;
      end
      chk("rst_mid_no_done", dn_cnt, 0);
      burst(1'b0, 0, 2, 0, 0, 5, 3);       // A5 A4

      burst(1'b1, 3, 4, 0, 0, -1, -2);
      burst(1'b1, 30, 4, 0, 0, -1, -2);
      burst(1'b1, 12, 8, 10, 0, -1, -2);

      repeat (4) @(negedge clk);
      chk("queue_a_empty", qa.size(), 0);
      chk("queue_b_empty", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
